// File: rtl/scmp_bus_pkg.sv
// Shared definitions for the SC/MP bus UART: register map, STATUS bit positions,
// serial engine state encodings and the divisor clamp helper.
package scmp_bus_pkg;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_DIV_LO = 2'd2;
    localparam logic [1:0] REG_DIV_HI = 2'd3;

    localparam int ST_RX_VALID = 0;
    localparam int ST_TX_FULL  = 1;
    localparam int ST_TX_EMPTY = 2;
    localparam int ST_OVERRUN  = 3;
    localparam int ST_TX_BUSY  = 4;
    localparam int ST_TX_IE    = 5;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } uart_tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } uart_rx_state_t;

    // A divisor of 0 or 1 cannot give a half-bit point, so it runs as 2.
    function automatic logic [15:0] eff_div(input logic [15:0] d);
        return (d < 16'd2) ? 16'd2 : d;
    endfunction

endpackage

// File: rtl/scmp_bus_if.sv
// SC/MP CPU bus as seen by a memory-mapped responder: strobes, address, CPU data out
// and the responder's read data with its output-enable.
interface scmp_bus_if;

    // Strobes are active low and level-sampled by the responder clock; a transfer
    // completes on the rising edge of RD_n or WR_n. rd_data is meaningful only
    // while rd_oe=1.
    logic        ADS_n;
    logic        RD_n;
    logic        WR_n;
    logic [11:0] addr;
    logic [7:0]  D_o;
    logic [7:0]  rd_data;
    logic        rd_oe;

    modport master (
        output ADS_n, RD_n, WR_n, addr, D_o,
        input  rd_data, rd_oe
    );

    modport slave (
        input  ADS_n, RD_n, WR_n, addr, D_o,
        output rd_data, rd_oe
    );

endinterface

// File: rtl/scmp_sync_fifo.sv
// Small synchronous FIFO with combinational read of the head entry.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module scmp_sync_fifo #(
    parameter int AW = 2,
    parameter int W  = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [W-1:0]  wdata,
    input  logic          pop,
    output logic [W-1:0]  rdata,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);

    localparam int DEPTH = 1 << AW;
    localparam logic [AW:0] FULL_CNT = {1'b1, {AW{1'b0}}};

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    assign do_pop  = pop & (count_q != '0);
    assign do_push = push & ((count_q != FULL_CNT) | do_pop);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);
    assign count = count_q;

endmodule

// File: rtl/scmp_bus_uart.sv
// SC/MP bus responder exposing an 8N1 UART in a 4-byte window of one address page:
// bus decode, DATA/STATUS/divisor registers, TX FIFO + shifter and RX engine.
module scmp_bus_uart
    import scmp_bus_pkg::*;
#(
    parameter logic [3:0]  PAGE    = 4'h1,
    parameter logic [11:0] BASE    = 12'hF00,
    parameter int          FIFO_AW = 2,
    parameter logic [15:0] DIV_RST = 16'd434
) (
    input  logic             clk,
    input  logic             rst_n,
    scmp_bus_if.slave        bus,
    input  logic             rx,
    output logic             tx,
    output logic             irq,
    output uart_tx_state_t   tx_state_o,
    output uart_rx_state_t   rx_state_o,
    output logic [FIFO_AW:0] tx_fifo_count_o
);

    // Bus front end and register file
    logic [3:0]  page_q, page_d;
    logic        rd_n_q, wr_n_q;
    logic [7:0]  wdata_q, wdata_d;
    logic [7:0]  rd_data_q, rd_data_d;
    logic [7:0]  rx_buf_q, rx_buf_d;
    logic        rx_valid_q, rx_valid_d;
    logic        overrun_q, overrun_d;
    logic        tx_ie_q, tx_ie_d;
    logic [15:0] div_q, div_d;
    logic        sel, rd_rise, wr_rise;
    logic [1:0]  reg_idx;
    logic [7:0]  status;
    logic [15:0] div_eff;

    // TX engine
    uart_tx_state_t tx_state_q, tx_state_d;
    logic [15:0] tx_cnt_q, tx_cnt_d;
    logic [7:0]  tx_shift_q, tx_shift_d;
    logic [2:0]  tx_bit_q, tx_bit_d;
    logic        tx_push, tx_pop;
    logic [7:0]  fifo_rdata;
    logic        tx_full, tx_empty, tx_busy;

    // RX engine
    uart_rx_state_t rx_state_q, rx_state_d;
    logic [15:0] rx_cnt_q, rx_cnt_d;
    logic [7:0]  rx_shift_q, rx_shift_d;
    logic [2:0]  rx_bit_q, rx_bit_d;
    logic        rx_s1_q, rx_s2_q;
    logic        rx_done;

    assign reg_idx = bus.addr[1:0];
    assign sel     = (page_q == PAGE) && (bus.addr[11:2] == BASE[11:2]);
    assign rd_rise = ~rd_n_q & bus.RD_n & sel;
    assign wr_rise = ~wr_n_q & bus.WR_n & sel;
    assign div_eff = eff_div(div_q);
    assign tx_busy = (tx_state_q != TX_IDLE);

    always_comb begin
        status              = 8'h00;
        status[ST_RX_VALID] = rx_valid_q;
        status[ST_TX_FULL]  = tx_full;
        status[ST_TX_EMPTY] = tx_empty;
        status[ST_OVERRUN]  = overrun_q;
        status[ST_TX_BUSY]  = tx_busy;
        status[ST_TX_IE]    = tx_ie_q;
    end

    always_comb begin
        page_d     = page_q;
        wdata_d    = wdata_q;
        rd_data_d  = rd_data_q;
        rx_buf_d   = rx_buf_q;
        rx_valid_d = rx_valid_q;
        overrun_d  = overrun_q;
        tx_ie_d    = tx_ie_q;
        div_d      = div_q;
        tx_push    = 1'b0;

        if (!bus.ADS_n) page_d = bus.D_o[3:0];
        if (!bus.WR_n) wdata_d = bus.D_o;

        case (reg_idx)
            REG_DATA:   rd_data_d = rx_buf_q;
            REG_STATUS: rd_data_d = status;
            REG_DIV_LO: rd_data_d = div_q[7:0];
            REG_DIV_HI: rd_data_d = div_q[15:8];
            default:    rd_data_d = 8'h00;
        endcase

        if (wr_rise) begin
            case (reg_idx)
                REG_DATA:   tx_push = 1'b1;
                REG_STATUS: begin
                    tx_ie_d = wdata_q[ST_TX_IE];
                    if (wdata_q[ST_OVERRUN]) overrun_d = 1'b0;
                end
                REG_DIV_LO: div_d[7:0]  = wdata_q;
                REG_DIV_HI: div_d[15:8] = wdata_q;
                default:    tx_push = 1'b0;
            endcase
        end

        if (rd_rise && (reg_idx == REG_DATA)) rx_valid_d = 1'b0;

        // A frame landing on the same edge as the DATA read counts as fresh, not overrun.
        if (rx_done) begin
            rx_buf_d = rx_shift_q;
            if (rx_valid_d) overrun_d = 1'b1;
            rx_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            page_q     <= 4'h0;
            rd_n_q     <= 1'b1;
            wr_n_q     <= 1'b1;
            wdata_q    <= 8'h00;
            rd_data_q  <= 8'h00;
            rx_buf_q   <= 8'h00;
            rx_valid_q <= 1'b0;
            overrun_q  <= 1'b0;
            tx_ie_q    <= 1'b0;
            div_q      <= DIV_RST;
        end else begin
            page_q     <= page_d;
            rd_n_q     <= bus.RD_n;
            wr_n_q     <= bus.WR_n;
            wdata_q    <= wdata_d;
            rd_data_q  <= rd_data_d;
            rx_buf_q   <= rx_buf_d;
            rx_valid_q <= rx_valid_d;
            overrun_q  <= overrun_d;
            tx_ie_q    <= tx_ie_d;
            div_q      <= div_d;
        end
    end

    assign bus.rd_data = rd_data_q;
    assign bus.rd_oe   = sel & ~bus.RD_n;
    assign irq         = rx_valid_q | (tx_empty & tx_ie_q);

    scmp_sync_fifo #(.AW(FIFO_AW), .W(8)) u_tx_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (tx_push),
        .wdata (wdata_q),
        .pop   (tx_pop),
        .rdata (fifo_rdata),
        .full  (tx_full),
        .empty (tx_empty),
        .count (tx_fifo_count_o)
    );

    // TX: STOP chains straight into START when another byte is waiting.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_shift_d = tx_shift_q;
        tx_bit_d   = tx_bit_q;
        tx_pop     = 1'b0;
        case (tx_state_q)
            TX_IDLE: begin
                if (!tx_empty) begin
                    tx_pop     = 1'b1;
                    tx_shift_d = fifo_rdata;
                    tx_cnt_d   = div_eff - 16'd1;
                    tx_state_d = TX_START;
                end
            end
            TX_START: begin
                if (tx_cnt_q == 16'd0) begin
                    tx_cnt_d   = div_eff - 16'd1;
                    tx_bit_d   = 3'd0;
                    tx_state_d = TX_DATA;
                end else begin
                    tx_cnt_d = tx_cnt_q - 16'd1;
                end
            end
            TX_DATA: begin
                if (tx_cnt_q == 16'd0) begin
                    tx_cnt_d = div_eff - 16'd1;
                    if (tx_bit_q == 3'd7) begin
                        tx_state_d = TX_STOP;
                    end else begin
                        tx_shift_d = {1'b0, tx_shift_q[7:1]};
                        tx_bit_d   = tx_bit_q + 3'd1;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q - 16'd1;
                end
            end
            TX_STOP: begin
                if (tx_cnt_q == 16'd0) begin
                    if (!tx_empty) begin
                        tx_pop     = 1'b1;
                        tx_shift_d = fifo_rdata;
                        tx_cnt_d   = div_eff - 16'd1;
                        tx_state_d = TX_START;
                    end else begin
                        tx_state_d = TX_IDLE;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q - 16'd1;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    // Line level comes straight from the state so an asynchronous reset idles it at once.
    always_comb begin
        case (tx_state_q)
            TX_START: tx = 1'b0;
            TX_DATA:  tx = tx_shift_q[0];
            default:  tx = 1'b1;
        endcase
    end

    // RX: sample at mid-start, then one sample per bit period.
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_shift_d = rx_shift_q;
        rx_bit_d   = rx_bit_q;
        rx_done    = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                if (!rx_s2_q) begin
                    rx_cnt_d   = (div_eff >> 1) - 16'd1;
                    rx_state_d = RX_START;
                end
            end
            RX_START: begin
                if (rx_cnt_q == 16'd0) begin
                    if (rx_s2_q) begin
                        rx_state_d = RX_IDLE;
                    end else begin
                        rx_cnt_d   = div_eff - 16'd1;
                        rx_bit_d   = 3'd0;
                        rx_state_d = RX_DATA;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q - 16'd1;
                end
            end
            RX_DATA: begin
                if (rx_cnt_q == 16'd0) begin
                    rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
                    rx_cnt_d   = div_eff - 16'd1;
                    if (rx_bit_q == 3'd7) begin
                        rx_state_d = RX_STOP;
                    end else begin
                        rx_bit_d = rx_bit_q + 3'd1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q - 16'd1;
                end
            end
            RX_STOP: begin
                if (rx_cnt_q == 16'd0) begin
                    rx_done    = rx_s2_q;
                    rx_state_d = RX_IDLE;
                end else begin
                    rx_cnt_d = rx_cnt_q - 16'd1;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= 16'd0;
            tx_shift_q <= 8'h00;
            tx_bit_q   <= 3'd0;
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= 16'd0;
            rx_shift_q <= 8'h00;
            rx_bit_q   <= 3'd0;
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_shift_q <= tx_shift_d;
            tx_bit_q   <= tx_bit_d;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_shift_q <= rx_shift_d;
            rx_bit_q   <= rx_bit_d;
            rx_s1_q    <= rx;
            rx_s2_q    <= rx_s1_q;
        end
    end

    assign tx_state_o = tx_state_q;
    assign rx_state_o = rx_state_q;

endmodule

// File: tb/tb_scmp_bus_uart.sv
// Directed bench for scmp_bus_uart: bus transactions, serial frames, and a per-cycle
// compare of rd_oe and the tx line against a byte-level model of the UART.
module tb_scmp_bus_uart;
    import scmp_bus_pkg::*;

    localparam logic [3:0]  PAGE = 4'h1;
    localparam logic [11:0] BASE = 12'hF00;

    logic clk = 1'b0;
    logic rst_n;
    logic rx;
    logic tx;
    logic irq;
    uart_tx_state_t tx_st;
    uart_rx_state_t rx_st;
    logic [2:0] fifo_cnt;

    scmp_bus_if bus();

    scmp_bus_uart #(.PAGE(4'h1), .BASE(12'hF00), .FIFO_AW(2), .DIV_RST(16'd434)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .bus             (bus),
        .rx              (rx),
        .tx              (tx),
        .irq             (irq),
        .tx_state_o      (tx_st),
        .rx_state_o      (rx_st),
        .tx_fifo_count_o (fifo_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;

    // Model state: exp_q holds bytes accepted by the TX FIFO and not yet started on the line.
    logic [7:0] exp_q[$];
    int         frame_t[$];
    int         tb_div = 434;
    logic [15:0] m_div = 16'd434;
    bit         m_tx_ie = 1'b0;
    bit         m_rx_valid = 1'b0;
    bit         m_overrun = 1'b0;
    logic [7:0] m_rx_buf = 8'h00;
    logic [3:0] page_m = 4'h0;
    bit         mon_active = 1'b0;
    int         mon_cyc = 0;
    int         mon_k = 0;
    logic [7:0] mon_byte = 8'h00;
    logic [7:0] last_tx_byte = 8'h00;
    int         frames_done = 0;
    int         cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] status_model();
        return {2'b00, m_tx_ie, mon_active, m_overrun, (exp_q.size() == 0),
                (exp_q.size() == 4), m_rx_valid};
    endfunction

    task automatic model_reset();
        m_div      = 16'd434;
        tb_div     = 434;
        m_tx_ie    = 1'b0;
        m_rx_valid = 1'b0;
        m_overrun  = 1'b0;
        m_rx_buf   = 8'h00;
        exp_q.delete();
    endtask

    task automatic model_write(input logic [3:0] pg, input logic [11:0] a, input logic [7:0] d);
        if (pg == PAGE && a[11:2] == BASE[11:2]) begin
            case (a[1:0])
                2'd0: if (exp_q.size() < 4) exp_q.push_back(d);
                2'd1: begin
                    m_tx_ie = d[5];
                    if (d[3]) m_overrun = 1'b0;
                end
                2'd2: m_div[7:0] = d;
                default: m_div[15:8] = d;
            endcase
            tb_div = (m_div < 16'd2) ? 2 : int'(m_div);
        end
    endtask

    // Per-cycle compare: rd_oe from the decode rule, tx from the expected frame bits.
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            check("tx_in_reset", tx, 1'b1);
            check("rd_oe_in_reset", bus.rd_oe, 1'b0);
            mon_active = 1'b0;
            page_m = 4'h0;
            exp_q.delete();
        end else begin
            check("rd_oe", bus.rd_oe,
                  (page_m == PAGE) && (bus.addr[11:2] == BASE[11:2]) && !bus.RD_n);
            if (!bus.ADS_n) page_m = bus.D_o[3:0];
            if (mon_active) begin
                mon_k = mon_cyc / tb_div;
                check("tx_bit", tx, (mon_k == 0) ? 1'b0 : (mon_k == 9) ? 1'b1 : mon_byte[mon_k-1]);
                mon_cyc++;
                if (mon_cyc == 10 * tb_div) begin
                    mon_active = 1'b0;
                    last_tx_byte = mon_byte;
                    frames_done++;
                end
            end else if (exp_q.size() == 0) begin
                check("tx_idle", tx, 1'b1);
            end else if (tx == 1'b0) begin
                mon_byte = exp_q.pop_front();
                mon_active = 1'b1;
                mon_cyc = 1;
                frame_t.push_back(cyc);
            end
        end
    end

    task automatic bus_idle();
        bus.ADS_n = 1'b1;
        bus.RD_n  = 1'b1;
        bus.WR_n  = 1'b1;
        bus.addr  = 12'h000;
        bus.D_o   = 8'h00;
    endtask

    task automatic bus_write(input logic [3:0] pg, input logic [11:0] a, input logic [7:0] d);
        @(posedge clk); #1;
        bus.ADS_n = 1'b0; bus.D_o = {4'h0, pg}; bus.addr = a;
        @(posedge clk); #1;
        bus.ADS_n = 1'b1; bus.D_o = d; bus.WR_n = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus.WR_n = 1'b1;
        model_write(pg, a, d);
        @(posedge clk); #1;
        bus.addr = 12'h000; bus.D_o = 8'h00;
    endtask

    task automatic bus_read(input logic [3:0] pg, input logic [11:0] a,
                            output logic [7:0] d, output logic oe);
        @(posedge clk); #1;
        bus.ADS_n = 1'b0; bus.D_o = {4'h0, pg}; bus.addr = a;
        @(posedge clk); #1;
        bus.ADS_n = 1'b1; bus.D_o = 8'h00; bus.RD_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        d = bus.rd_data;
        oe = bus.rd_oe;
        @(posedge clk); #1;
        bus.RD_n = 1'b1;
        @(posedge clk); #1;
        bus.addr = 12'h000;
        if (pg == PAGE && a[11:2] == BASE[11:2] && a[1:0] == 2'd0) m_rx_valid = 1'b0;
    endtask

    task automatic read_chk(input string name, input logic [11:0] a, input logic [7:0] lit);
        logic [7:0] d;
        logic oe;
        bus_read(PAGE, a, d, oe);
        check({name, "_oe"}, oe, 1'b1);
        check(name, d, lit);
    endtask

    task automatic status_chk(input string name, input logic [7:0] lit);
        logic [7:0] d;
        logic oe;
        logic [7:0] m;
        bus_read(PAGE, 12'hF01, d, oe);
        m = status_model();
        check({name, "_oe"}, oe, 1'b1);
        check(name, d, lit);
        check({name, "_model"}, d, m);
    endtask

    task automatic set_div(input logic [15:0] d);
        bus_write(PAGE, 12'hF02, d[7:0]);
        bus_write(PAGE, 12'hF03, d[15:8]);
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop);
        logic [9:0] fr;
        fr = {stop, b, 1'b0};
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            rx = fr[k];
            repeat (tb_div - 1) @(posedge clk);
        end
        @(posedge clk); #1;
        rx = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        if (stop) begin
            if (m_rx_valid) m_overrun = 1'b1;
            m_rx_valid = 1'b1;
            m_rx_buf = b;
        end
    endtask

    task automatic wait_tx_done(input int limit);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || mon_active) && n < limit) begin
            @(posedge clk);
            n++;
        end
        check("tx_drain_in_time", (n < limit), 1'b1);
        @(negedge clk);
    endtask

    initial begin
        logic [7:0] d;
        logic oe;
        int fd0;
        logic [7:0] burst[5];

        rst_n = 1'b0;
        rx = 1'b1;
        bus_idle();
        model_reset();

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("tx_reset", tx, 1'b1);
        check("irq_reset", irq, 1'b0);
        check("rd_oe_reset", bus.rd_oe, 1'b0);
        check("fifo_cnt_reset", fifo_cnt, 3'd0);
        check("tx_state_reset", tx_st, TX_IDLE);
        check("rx_state_reset", rx_st, RX_IDLE);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        status_chk("status_after_reset", 8'h04);
        read_chk("div_lo_reset", 12'hF02, 8'hB2);
        read_chk("div_hi_reset", 12'hF03, 8'h01);

        // Single frame at div=4
        set_div(16'd4);
        read_chk("div_lo_4", 12'hF02, 8'h04);
        bus_write(PAGE, 12'hF00, 8'h55);
        status_chk("status_tx_busy", 8'h14);
        wait_tx_done(200);
        check("tx_byte_55", last_tx_byte, 8'h55);
        status_chk("status_after_stop", 8'h04);

        // FIFO fill behind a running frame, overflow drop, gapless chaining
        set_div(16'd8);
        frame_t.delete();
        fd0 = frames_done;
        bus_write(PAGE, 12'hF00, 8'h3C);
        burst[0] = 8'hA0; burst[1] = 8'hA1; burst[2] = 8'hA2; burst[3] = 8'hA3; burst[4] = 8'hA4;
        for (int i = 0; i < 5; i++) bus_write(PAGE, 12'hF00, burst[i]);
        status_chk("status_fifo_full", 8'h12);
        check("irq_tx_ie_off", irq, 1'b0);
        wait_tx_done(1000);
        check("frames_sent", frames_done - fd0, 5);
        check("last_byte_a3", last_tx_byte, 8'hA3);
        check("frame_starts", frame_t.size(), 5);
        for (int i = 1; i < frame_t.size(); i++) begin
            check("tx_gapless", frame_t[i] - frame_t[i-1], 80);
        end

        // RX: valid, read clear, overrun, overrun clear, bad stop bit, tx_ie
        send_rx(8'hC3, 1'b1);
        status_chk("status_rx_valid", 8'h05);
        check("irq_rx_valid", irq, 1'b1);
        read_chk("rx_data_c3", 12'hF00, 8'hC3);
        status_chk("status_rx_cleared", 8'h04);
        check("irq_rx_cleared", irq, 1'b0);
        send_rx(8'h5A, 1'b1);
        send_rx(8'h96, 1'b1);
        status_chk("status_overrun", 8'h0D);
        read_chk("rx_data_96", 12'hF00, 8'h96);
        status_chk("status_overrun_kept", 8'h0C);
        bus_write(PAGE, 12'hF01, 8'h08);
        status_chk("status_overrun_clr", 8'h04);
        send_rx(8'h11, 1'b0);
        status_chk("status_bad_stop", 8'h04);
        bus_write(PAGE, 12'hF01, 8'h20);
        status_chk("status_tx_ie", 8'h24);
        check("irq_tx_ie", irq, 1'b1);
        bus_write(PAGE, 12'hF01, 8'h00);
        check("irq_tx_ie_clr", irq, 1'b0);

        // Page/window mismatch and rx glitch
        bus_write(4'h0, 12'hF00, 8'h77);
        bus_read(4'h0, 12'hF00, d, oe);
        check("rd_oe_page0", oe, 1'b0);
        bus_write(PAGE, 12'hF04, 8'h66);
        repeat (30) @(posedge clk);
        check("fifo_cnt_no_push", fifo_cnt, 3'd0);
        @(posedge clk); #1;
        rx = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rx = 1'b1;
        repeat (30) @(posedge clk);
        status_chk("status_glitch", 8'h04);

        // Reset in the middle of a frame
        set_div(16'd4);
        bus_write(PAGE, 12'hF00, 8'h81);
        bus_write(PAGE, 12'hF00, 8'h7E);
        repeat (6) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("tx_async_reset", tx, 1'b1);
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        status_chk("status_after_mid_reset", 8'h04);
        read_chk("div_lo_after_reset", 12'hF02, 8'hB2);
        read_chk("div_hi_after_reset", 12'hF03, 8'h01);
        repeat (40) @(posedge clk);
        check("tx_leftover", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached at %0t", $time);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
